// File: rtl/divu_seq.sv
// Unsigned restoring divider, one quotient bit per cycle (quotient for LO, remainder for HI).
// Latency WIDTH cycles from accepted start to done; `DIVU_FAST_ZERO_EN makes a zero divisor finish after one ZERO cycle.
// No backpressure: start is only honoured while busy==0, and results hold until the next completion.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ZERO} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r, r_sh, r_nxt;
  logic [WIDTH-1:0] q, q_nxt, divisor;
  logic             accept, last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          accept = 1'b1;
`ifdef DIVU_FAST_ZERO_EN
          state_nxt = (dataB == '0) ? S_ZERO : S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
`ifdef DIVU_FAST_ZERO_EN
      S_ZERO: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    q_nxt = {q[WIDTH-2:0], 1'b0};
    r_nxt = r_sh;
    if (r_sh >= {1'b0, divisor}) begin
      r_nxt    = r_sh - {1'b0, divisor};
      q_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      divisor     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q       <= dataA;
      divisor <= dataB;
      r       <= '0;
      cnt     <= '0;
    end else if (state == S_RUN) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[WIDTH-1:0];
        div_by_zero <= (divisor == '0);
      end
    end
`ifdef DIVU_FAST_ZERO_EN
    // q still holds the untouched dividend here
    else if (state == S_ZERO) begin
      quotient    <= '1;
      remainder   <= q;
      div_by_zero <= 1'b1;
    end
`endif
  end

endmodule
